// File: rtl/order_book_pkg.sv
// Shared constants, requester indices and FSM state type for the order RAM arbiter.
package order_book_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 48;

  localparam int REQ_INSERT = 0;
  localparam int REQ_CANCEL = 1;
  localparam int REQ_SCAN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    if (oh[REQ_SCAN])        onehot_idx = 2'(REQ_SCAN);
    else if (oh[REQ_CANCEL]) onehot_idx = 2'(REQ_CANCEL);
    else                     onehot_idx = 2'(REQ_INSERT);
  endfunction

endpackage

// File: rtl/order_ram_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters, searching from last_winner+1.
module rr_pick3
  import order_book_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last_winner,
  output logic [2:0] o_winner
);

  logic [2:0] w_rot;
  logic [2:0] w_sel;

  // Rotate so bit 0 is the first candidate, priority-encode, rotate back.
  always_comb begin
    w_rot    = i_req;
    w_sel    = 3'b000;
    o_winner = 3'b000;
    case (i_last_winner)
      2'd0:    w_rot = {i_req[0], i_req[2], i_req[1]};
      2'd1:    w_rot = {i_req[1], i_req[0], i_req[2]};
      default: w_rot = i_req;
    endcase
    if (w_rot[0])      w_sel = 3'b001;
    else if (w_rot[1]) w_sel = 3'b010;
    else if (w_rot[2]) w_sel = 3'b100;
    case (i_last_winner)
      2'd0:    o_winner = {w_sel[1], w_sel[0], w_sel[2]};
      2'd1:    o_winner = {w_sel[0], w_sel[2], w_sel[1]};
      default: o_winner = w_sel;
    endcase
  end

endmodule

// File: rtl/order_ram_arbiter.sv
// Three-way single-port order RAM arbiter with round-robin ownership and 1-cycle read return.
// Define ORDER_RAM_ARB_WDOG_EN to bound ownership to WDOG_CYCLES with a forced revoke.
//
// state    | meaning
// ST_IDLE  | no owner; pick a round-robin winner when any req is high
// ST_OWN   | owner's slices drive the RAM while its req stays high
// ST_DRAIN | one cycle after release/revoke; final rvalid delivered, no grant
module order_ram_arbiter
  import order_book_pkg::*;
#(
  parameter int ADDR_W      = order_book_pkg::ADDR_W,
  parameter int DATA_W      = order_book_pkg::DATA_W,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   addr_in,
  input  logic [3*DATA_W-1:0]   wdata_in,
  input  logic [2:0]            we_in,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  wdog_flag
);

  arb_state_t r_state, w_state_nxt;
  logic [2:0] r_gnt, w_gnt_nxt, w_pick;
  logic [1:0] r_last, w_last_nxt;
  logic [2:0] r_rvalid;
  logic       w_owner_req;
  logic       w_revoke;
  logic       w_grant;

  rr_pick3 u_pick (
    .i_req         (req),
    .i_last_winner (r_last),
    .o_winner      (w_pick)
  );

  assign w_owner_req = |(r_gnt & req);

`ifdef ORDER_RAM_ARB_WDOG_EN
  localparam int HOLD_W = $clog2(WDOG_CYCLES + 1);
  logic [HOLD_W-1:0] r_hold;
  logic              r_wdog;

  // Down-counter loaded at grant; terminal count on the last permitted OWN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_wdog <= 1'b0;
    end else begin
      r_wdog <= w_revoke;
      if (w_grant)
        r_hold <= HOLD_W'(WDOG_CYCLES - 1);
      else if (r_state == ST_OWN && r_hold != '0)
        r_hold <= r_hold - 1'b1;
    end
  end

  assign w_revoke  = (r_state == ST_OWN) && (r_hold == '0) && w_owner_req;
  assign wdog_flag = r_wdog;
`else
  // Hold limit parameter has no effect in this build; ownership is unbounded.
  assign w_revoke  = (WDOG_CYCLES < 0);
  assign wdog_flag = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_gnt_nxt   = w_pick;
          w_last_nxt  = onehot_idx(w_pick);
          w_state_nxt = ST_OWN;
          w_grant     = 1'b1;
        end
      end
      ST_OWN: begin
        if (!w_owner_req || w_revoke) begin
          w_gnt_nxt   = 3'b000;
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_gnt_nxt   = 3'b000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 3'b000;
      r_last   <= 2'(REQ_SCAN);
      r_rvalid <= 3'b000;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_last   <= w_last_nxt;
      r_rvalid <= (r_state == ST_OWN) ? (r_gnt & ~we_in) : 3'b000;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (r_state == ST_OWN && r_gnt[k]) begin
        ram_addr  = addr_in[k*ADDR_W +: ADDR_W];
        ram_wdata = wdata_in[k*DATA_W +: DATA_W];
        ram_we    = we_in[k];
      end
    end
  end

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = (|r_rvalid) ? ram_rdata : '0;

endmodule

// File: doc/order_ram_arbiter.md
ORDER_RAM_ARBITER -- requirements
Module: order_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, order RAM address width (4096 entries).
REQ-002 The block SHALL have parameter DATA_W, default 48, order word width; price in bits [15:0].
REQ-003 The block SHALL have parameter WDOG_CYCLES, default 64, maximum grant hold time in cycles.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 3, per-requester access request: 0 = order insert, 1 = order cancel, 2 = best-limit scan.
REQ-007 The block SHALL have port addr_in, input, 3*ADDR_W, per-requester address; slice k belongs to requester k.
REQ-008 The block SHALL have port wdata_in, input, 3*DATA_W, per-requester write data; slice k belongs to requester k.
REQ-009 The block SHALL have port we_in, input, 3, per-requester write enable.
REQ-010 The block SHALL have port gnt, input-side-facing output, 3, one-hot ownership grant.
REQ-011 The block SHALL have port rvalid, output, 3, one-hot strobe marking rdata valid for requester k.
REQ-012 The block SHALL have port rdata, output, DATA_W, RAM read data broadcast to all requesters.
REQ-013 The block SHALL have ports ram_addr (output, ADDR_W), ram_wdata (output, DATA_W), ram_we (output, 1) and ram_rdata (input, DATA_W) to the single-port order RAM.
REQ-014 The block SHALL have port wdog_flag, output, 1, one-cycle pulse on forced revoke.

Function
REQ-015 The FSM SHALL have the states IDLE, OWN and DRAIN.
REQ-016 In IDLE with any req high, the FSM SHALL select a winner round-robin, searching from (last_winner+1) mod 3, assert gnt for it on the next edge and enter OWN.
REQ-017 In OWN, ram_addr/ram_wdata/ram_we SHALL be driven combinationally from the owner's slices; ram_we SHALL be we_in[owner].
REQ-018 Non-owner addr/we SHALL never reach the RAM; with no owner, ram_we SHALL be 0 and ram_addr SHALL be 0.
REQ-019 A read (owner with we_in=0) issued in cycle t SHALL produce rvalid[owner]=1 with rdata=ram_rdata in cycle t+1, giving a 1-cycle RAM latency.
REQ-020 Ownership SHALL persist while req[owner]=1; when req[owner] falls, gnt SHALL clear on the next edge and the FSM SHALL enter DRAIN.
REQ-021 DRAIN SHALL last exactly one cycle, delivering any final rvalid, then enter IDLE; no grant SHALL be issued during DRAIN.
REQ-022 last_winner SHALL update on each grant; after reset it SHALL be 2, so requester 0 wins the first contention.
REQ-023 Requests arriving during OWN or DRAIN SHALL wait; no request SHALL be dropped while held high.
REQ-024 gnt SHALL always be one-hot or zero, and rvalid likewise.

Reset
REQ-025 On rst low, gnt, rvalid and wdog_flag SHALL be 0, rdata SHALL be 0, the FSM SHALL be in IDLE, last_winner SHALL be 2 and the hold counter SHALL be 0, all asynchronously.
REQ-026 Reset mid-OWN SHALL abort the access immediately; no rvalid SHALL follow.

Configuration
REQ-027 With ORDER_RAM_ARB_WDOG_EN defined, a hold counter SHALL count cycles in OWN.
REQ-028 With ORDER_RAM_ARB_WDOG_EN defined, reaching WDOG_CYCLES SHALL force gnt=0 and enter DRAIN, pulse wdog_flag for one cycle, and cause the revoked requester to lose priority for the next arbitration.
REQ-029 Without ORDER_RAM_ARB_WDOG_EN, no counter SHALL exist, wdog_flag SHALL be tied to 0 and ownership SHALL be unbounded.

Structure
REQ-030 The package order_book_pkg SHALL hold ADDR_W, DATA_W, requester index constants (REQ_INSERT=0, REQ_CANCEL=1, REQ_SCAN=2) and the FSM state enum.
REQ-031 The round-robin winner select SHALL be the sub-module rr_pick3, which is combinational, takes req and last_winner, and returns the one-hot winner.

Verification
REQ-032 The bench SHALL check that after reset, req=3'b111 gives gnt=001 first; on release of req[0], gnt=010 follows after one DRAIN cycle; then gnt=100.
REQ-033 The bench SHALL check that a scan owner reading addr 5 with the RAM holding 48'h0000_0000_0064 gives rvalid=100 and rdata=48'h64 in the next cycle.
REQ-034 The bench SHALL check that when the insert owner writes 48'hABCD at addr 10 while cancel drives we=1 at addr 10, ram_we=1 and ram_wdata=48'hABCD, and the cancel write is never seen.
REQ-035 The bench SHALL check that with ORDER_RAM_ARB_WDOG_EN and WDOG_CYCLES=4, a requester holding req for 10 cycles sees gnt drop after 4 cycles and wdog_flag pulse once.
REQ-036 The bench SHALL check that rst asserted in OWN immediately after a read issue gives gnt=0 and rvalid=0, with no rvalid after release.
REQ-037 The bench SHALL check that a single requester toggling req every 3 cycles is re-granted each time after IDLE, with no starvation of the others when they request.
